// File: rtl/pipe_hazard_pkg.sv
// Shared types and helpers for the hazard-detection / forwarding controller.
package pipe_hazard_pkg;

  localparam int unsigned DST_W = 8;
  localparam int unsigned LAT_W = 8;
  localparam logic [DST_W-1:0] ZERO_REG = '0;

  // dst/lat are sized for the widest supported configuration; users take the low bits
  typedef struct packed {
    logic             v;
    logic [DST_W-1:0] dst;
    logic [LAT_W-1:0] lat;
  } track_entry_t;

  function automatic int unsigned sel_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_hazard_fwd_src_match.sv
// Per-operand priority match against the post-ID tracker: forward select or hazard.
module src_match
  import pipe_hazard_pkg::*;
#(
  parameter int unsigned REG_W = 5,
  parameter int unsigned DEPTH = 3,
  parameter int unsigned SEL_W = sel_width(DEPTH)
) (
  input  logic [REG_W-1:0]         src_i,
  input  logic                     used_i,
  input  track_entry_t [DEPTH:1]   trk_i,
  output logic [SEL_W-1:0]         sel_o,
  output logic                     hazard_o
);

  logic        found;
  int unsigned hit_k;
  int unsigned hit_lat;

  always_comb begin
    found   = 1'b0;
    hit_k   = 0;
    hit_lat = 0;
    // lowest k is the youngest producer and wins
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      if (!found && trk_i[k].v && (trk_i[k].dst == DST_W'(src_i))) begin
        found   = 1'b1;
        hit_k   = k;
        hit_lat = 32'(trk_i[k].lat);
      end
    end

    sel_o    = '0;
    hazard_o = 1'b0;
    if (found && used_i && (DST_W'(src_i) != ZERO_REG)) begin
      if (hit_k < hit_lat) begin
        hazard_o = 1'b1;
      end else if (hit_k < DEPTH) begin
        sel_o = SEL_W'(hit_k + 1);
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_fwd.sv
// Hazard detection and forwarding-select generation beside the ID stage.
module pipe_hazard_fwd
  import pipe_hazard_pkg::*;
#(
  parameter int unsigned REG_W    = 5,
  parameter int unsigned NSRC     = 2,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned ALU_LAT  = 1,
  parameter int unsigned LOAD_LAT = 2,
  parameter int unsigned SEL_W    = sel_width(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid,
  input  logic [NSRC*REG_W-1:0]   id_src,
  input  logic [NSRC-1:0]         id_src_used,
  input  logic [REG_W-1:0]        id_dst,
  input  logic                    id_wr,
  input  logic                    id_load,
  input  logic                    id_flush,
  output logic                    stall,
  output logic [NSRC*SEL_W-1:0]   ex_fwd_sel,
  output logic [15:0]             stall_cnt
);

  track_entry_t [DEPTH:1]  trk_q, trk_d;
  logic [NSRC-1:0]         hazard;
  logic [NSRC*SEL_W-1:0]   sel_all, fwd_sel_q, fwd_sel_d;
  logic [15:0]             stall_cnt_q, stall_cnt_d;
  logic                    issue;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    src_match #(
      .REG_W (REG_W),
      .DEPTH (DEPTH),
      .SEL_W (SEL_W)
    ) u_match (
      .src_i    (id_src[i*REG_W +: REG_W]),
      .used_i   (id_src_used[i]),
      .trk_i    (trk_q),
      .sel_o    (sel_all[i*SEL_W +: SEL_W]),
      .hazard_o (hazard[i])
    );
  end

  assign stall = id_valid & ~id_flush & (|hazard);
  assign issue = id_valid & ~id_flush & ~stall;

  always_comb begin
    trk_d = '0;
    if (issue && id_wr && (DST_W'(id_dst) != ZERO_REG)) begin
      trk_d[1].v   = 1'b1;
      trk_d[1].dst = DST_W'(id_dst);
      trk_d[1].lat = id_load ? LAT_W'(LOAD_LAT) : LAT_W'(ALU_LAT);
    end
    for (int unsigned k = 2; k <= DEPTH; k++) begin
      trk_d[k] = trk_q[k-1];
    end

    fwd_sel_d   = issue ? sel_all : '0;
    stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + 16'd1 : stall_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trk_q       <= '0;
      fwd_sel_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      trk_q       <= trk_d;
      fwd_sel_q   <= fwd_sel_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_fwd_sel = fwd_sel_q;
  assign stall_cnt  = stall_cnt_q;

endmodule
